// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle: write port, two read ports and debug status.
// master drives addresses/write data; slave returns read data and status.
interface reg_file_2r1w_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr_a;
   logic [ADDR_W-1:0] raddr_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic [7:0]        wr_cnt;
   logic              busy_r0;

   modport master (
      output we, waddr, wdata, raddr_a, raddr_b,
      input  rdata_a, rdata_b, wr_cnt, busy_r0
   );

   modport slave (
      input  we, waddr, wdata, raddr_a, raddr_b,
      output rdata_a, rdata_b, wr_cnt, busy_r0
   );
endinterface

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file, r0 hardwired to 0; writes land in 1 cycle, reads are
// combinational with same-cycle write bypass; no backpressure, every write is accepted.
module reg_file_2r1w #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input logic             clk,
   input logic             rst_n,
   reg_file_2r1w_if.slave  rf
);
   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [NREG];
   logic [7:0]        wr_cnt_q, wr_cnt_d;
   logic              busy_r0_q, busy_r0_d;
   logic              wr_acc;

   // rst_n gates acceptance so a write coincident with reset is dropped
   assign wr_acc = rst_n && rf.we && (rf.waddr != '0);

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (wr_acc && (wr_cnt_q != 8'hFF)) begin
         wr_cnt_d = wr_cnt_q + 8'd1;
      end
      busy_r0_d = rf.we && (rf.waddr == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
         wr_cnt_q  <= '0;
         busy_r0_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            mem_q[rf.waddr] <= rf.wdata;
         end
         wr_cnt_q  <= wr_cnt_d;
         busy_r0_q <= busy_r0_d;
      end
   end

   // Bypass forwards in-flight write data so decode sees it before the edge
   always_comb begin
      rf.rdata_a = '0;
      rf.rdata_b = '0;
      if (rst_n && (rf.raddr_a != '0)) begin
         rf.rdata_a = (wr_acc && (rf.waddr == rf.raddr_a)) ? rf.wdata : mem_q[rf.raddr_a];
      end
      if (rst_n && (rf.raddr_b != '0)) begin
         rf.rdata_b = (wr_acc && (rf.waddr == rf.raddr_b)) ? rf.wdata : mem_q[rf.raddr_b];
      end
   end

   assign rf.wr_cnt  = wr_cnt_q;
   assign rf.busy_r0 = busy_r0_q;
endmodule
